// File: rtl/three_phase_pwm_gen.sv
// Three-phase PWM: free-running 8-bit carrier, shadowed duties, per-phase dead-time FSM, latched fault.
// Gate drives are registered; a fault blanks all six drives on the same edge it latches.
module three_phase_pwm_gen #(
  parameter int unsigned DEAD_TIME = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] duty_a,
  input  logic [7:0] duty_b,
  input  logic [7:0] duty_c,
  input  logic       fault,
  input  logic       fault_clr,
  output logic       hi_a,
  output logic       lo_a,
  output logic       hi_b,
  output logic       lo_b,
  output logic       hi_c,
  output logic       lo_c,
  output logic       fault_latched,
  output logic       period_start
);

  typedef enum logic [1:0] {ST_DEAD, ST_HIGH, ST_LOW} state_e;

  localparam logic [3:0] DT_LAST = 4'(DEAD_TIME - 1);

  logic [7:0] cnt_q, cnt_d;
  logic [7:0] duty [3];
  logic [7:0] act_q [3];
  state_e     state_q [3];
  state_e     state_d [3];
  logic [3:0] dt_q [3];
  logic [3:0] dt_d [3];
  logic [2:0] raw;
  logic [2:0] raw_prev_q;
  logic [2:0] hi_q, lo_q;
  logic       fault_q, fault_d;
  logic       period_start_q;

  assign duty[0] = duty_a;
  assign duty[1] = duty_b;
  assign duty[2] = duty_c;

  always_comb begin
    cnt_d   = cnt_q + 8'd1;
    fault_d = fault ? 1'b1 : (fault_clr ? 1'b0 : fault_q);
    for (int i = 0; i < 3; i++) begin
      raw[i]     = en & ~fault_q & (cnt_q < act_q[i]);
      state_d[i] = state_q[i];
      dt_d[i]    = dt_q[i];
      case (state_q[i])
        ST_DEAD: begin
          // Any raw edge restarts the dead band; leave only after DEAD_TIME stable cycles.
          if (raw[i] != raw_prev_q[i]) begin
            dt_d[i] = 4'd0;
          end else if (dt_q[i] == DT_LAST) begin
            state_d[i] = raw[i] ? ST_HIGH : ST_LOW;
            dt_d[i]    = 4'd0;
          end else begin
            dt_d[i] = dt_q[i] + 4'd1;
          end
        end
        ST_HIGH: begin
          if (!raw[i]) begin
            state_d[i] = ST_DEAD;
            dt_d[i]    = 4'd0;
          end
        end
        ST_LOW: begin
          if (raw[i]) begin
            state_d[i] = ST_DEAD;
            dt_d[i]    = 4'd0;
          end
        end
        default: begin
          state_d[i] = ST_DEAD;
          dt_d[i]    = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q          <= 8'd0;
      fault_q        <= 1'b0;
      period_start_q <= 1'b0;
      raw_prev_q     <= 3'b000;
      hi_q           <= 3'b000;
      lo_q           <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        act_q[i]   <= 8'd0;
        state_q[i] <= ST_DEAD;
        dt_q[i]    <= 4'd0;
      end
    end else begin
      cnt_q          <= cnt_d;
      fault_q        <= fault_d;
      period_start_q <= (cnt_d == 8'd0);
      raw_prev_q     <= raw;
      for (int i = 0; i < 3; i++) begin
        if (cnt_q == 8'hFF) begin
          act_q[i] <= duty[i];
        end
        state_q[i] <= state_d[i];
        dt_q[i]    <= dt_d[i];
        // Masking with the next fault value blanks the drives on the latching edge itself.
        hi_q[i]    <= (state_d[i] == ST_HIGH) & ~fault_d;
        lo_q[i]    <= (state_d[i] == ST_LOW) & ~fault_d;
      end
    end
  end

  assign hi_a          = hi_q[0];
  assign lo_a          = lo_q[0];
  assign hi_b          = hi_q[1];
  assign lo_b          = lo_q[1];
  assign hi_c          = hi_q[2];
  assign lo_c          = lo_q[2];
  assign fault_latched = fault_q;
  assign period_start  = period_start_q;

endmodule

// File: tb/tb_three_phase_pwm_gen.sv
// Directed bench for three_phase_pwm_gen plus a randomized soak with a shoot-through/dead-band monitor.
module tb_three_phase_pwm_gen;

  localparam int DT = 4;

  logic       clk = 1'b0;
  logic       rst, en, fault, fault_clr;
  logic [7:0] duty_a, duty_b, duty_c;
  logic       hi_a, lo_a, hi_b, lo_b, hi_c, lo_c, fault_latched, period_start;

  logic [5:0] outs;
  logic [2:0] hv, lv;
  assign outs = {hi_a, lo_a, hi_b, lo_b, hi_c, lo_c};
  assign hv   = {hi_c, hi_b, hi_a};
  assign lv   = {lo_c, lo_b, lo_a};

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int nh [3];
  int nl [3];
  bit mon_en = 1'b0;
  int gap [3];
  int last_side [3];

  three_phase_pwm_gen #(.DEAD_TIME(DT)) dut (
    .clk(clk), .rst(rst), .en(en),
    .duty_a(duty_a), .duty_b(duty_b), .duty_c(duty_c),
    .fault(fault), .fault_clr(fault_clr),
    .hi_a(hi_a), .lo_a(lo_a), .hi_b(hi_b), .lo_b(lo_b), .hi_c(hi_c), .lo_c(lo_c),
    .fault_latched(fault_latched), .period_start(period_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic goto(input int target);
    while (cyc < target) step();
  endtask

  task automatic run_period(input int chg_at, input logic [7:0] chg_val);
    for (int p = 0; p < 3; p++) begin
      nh[p] = 0;
      nl[p] = 0;
    end
    for (int k = 0; k < 256; k++) begin
      if (k == chg_at) duty_a = chg_val;
      for (int p = 0; p < 3; p++) begin
        nh[p] += int'(hv[p]);
        nl[p] += int'(lv[p]);
      end
      step();
    end
  endtask

  // Shoot-through and dead-band monitor, active whenever mon_en is set.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int p = 0; p < 3; p++) begin
        checks++;
        assert ((hv[p] & lv[p]) === 1'b0) else begin
          errors++;
          $error("FAIL shoot_through phase %0d: observed hi&lo=1 expected 0 (cycle %0d)", p, cyc);
        end
        if (hv[p] | lv[p]) begin
          if (last_side[p] != 0 && last_side[p] != (hv[p] ? 1 : 2)) begin
            checks++;
            assert ((gap[p] >= DT) === 1'b1) else begin
              errors++;
              $error("FAIL dead_band phase %0d: observed gap %0d expected >= %0d (cycle %0d)", p, gap[p], DT, cyc);
            end
          end
          last_side[p] = hv[p] ? 1 : 2;
          gap[p] = 0;
        end else begin
          gap[p]++;
        end
      end
    end
  end

  initial begin
    for (int p = 0; p < 3; p++) begin
      gap[p] = 0;
      last_side[p] = 0;
    end
    rst = 1'b1; en = 1'b1; fault = 1'b0; fault_clr = 1'b0;
    duty_a = 8'd100; duty_b = 8'd3; duty_c = 8'd255;
    repeat (3) @(negedge clk);
    chk("reset_outs", 32'(outs), 0);
    chk("reset_fault", 32'(fault_latched), 0);
    chk("reset_pstart", 32'(period_start), 0);

    // Cycle 0 is the cycle with cnt == 0 right after release.
    rst = 1'b0; cyc = 0; mon_en = 1'b1;
    chk("rel_c0_outs", 32'(outs), 0);
    goto(3);  chk("rel_c3_outs", 32'(outs), 0);
    goto(4);  chk("rel_c4_lo", 32'(lv), 32'b111);
              chk("rel_c4_hi", 32'(hv), 0);
    goto(200); chk("p1_act0_lo", 32'(lv), 32'b111);
    goto(255); chk("pstart_255", 32'(period_start), 0);
    goto(256); chk("pstart_256", 32'(period_start), 1);
    goto(257); chk("pstart_257", 32'(period_start), 0);

    // Period 2 edges for duty_a = 100.
    goto(260); chk("a_hi_cnt4", 32'(hi_a), 0);
    goto(261); chk("a_hi_cnt5", 32'(hi_a), 1);
    goto(356); chk("a_hi_cnt100", 32'(hi_a), 1);
    goto(357); chk("a_hi_cnt101", 32'(hi_a), 0);
               chk("a_lo_cnt101", 32'(lo_a), 0);
    goto(360); chk("a_lo_cnt104", 32'(lo_a), 0);
    goto(361); chk("a_lo_cnt105", 32'(lo_a), 1);

    // Period 3 widths; duty_a changed mid-period must not affect it.
    goto(512);
    run_period(50, 8'd200);
    chk("p3_hi_a", nh[0], 96);
    chk("p3_lo_a", nl[0], 152);
    chk("p3_hi_b", nh[1], 0);
    chk("p3_lo_b", nl[1], 249);
    chk("p3_hi_c", nh[2], 251);
    chk("p3_lo_c", nl[2], 0);
    run_period(100, 8'd100);
    chk("p4_hi_a", nh[0], 196);
    chk("p4_lo_a", nl[0], 52);

    // Period 5: fault handling (base 1024).
    goto(1044); chk("f_pre_hi_a", 32'(hi_a), 1);
                chk("f_pre_latch", 32'(fault_latched), 0);
    fault = 1'b1;
    step();     chk("f_latch", 32'(fault_latched), 1);
                chk("f_outs", 32'(outs), 0);
    fault = 1'b0;
    goto(1064); chk("f_hold_outs", 32'(outs), 0);
                chk("f_hold_latch", 32'(fault_latched), 1);
    fault = 1'b1; fault_clr = 1'b1;
    step();     chk("f_both_latch", 32'(fault_latched), 1);
                chk("f_both_outs", 32'(outs), 0);
    fault = 1'b0;
    step();     chk("f_clr_latch", 32'(fault_latched), 0);
                chk("f_clr_lo", 32'(lv), 32'b111);
                chk("f_clr_hi", 32'(hv), 0);
    fault_clr = 1'b0;
    goto(1067); chk("f_a_dead", 32'({hi_a, lo_a}), 0);
    goto(1070); chk("f_a_hi_cnt46", 32'(hi_a), 0);
    goto(1071); chk("f_a_hi_cnt47", 32'(hi_a), 1);
                chk("f_c_hi_cnt47", 32'(hi_c), 1);

    // Period 6: en = 0 brakes to low side through dead time.
    goto(1290); chk("en_pre_hi_a", 32'(hi_a), 1);
    en = 1'b0;
    step();     chk("en_a_dead", 32'({hi_a, lo_a}), 0);
    goto(1294); chk("en_lo_cnt14", 32'(lo_a), 0);
    goto(1295); chk("en_lo_cnt15", 32'(lo_a), 1);
    goto(1536); chk("en_pstart", 32'(period_start), 1);
                chk("en_all_lo", 32'(lv), 32'b111);
    en = 1'b1;

    // Mid-period reset aborts immediately and clears the shadow duties.
    goto(1566); chk("mr_pre_hi_a", 32'(hi_a), 1);
    rst = 1'b1;
    step();     chk("mr_outs", 32'(outs), 0);
                chk("mr_pstart", 32'(period_start), 0);
    rst = 1'b0; cyc = 0;
    goto(3);   chk("mr_c3_lo_a", 32'(lo_a), 0);
    goto(4);   chk("mr_c4_lo_a", 32'(lo_a), 1);
    goto(50);  chk("mr_act0_lo_a", 32'(lo_a), 1);
               chk("mr_act0_hi_a", 32'(hi_a), 0);
    goto(256); chk("mr_pstart", 32'(period_start), 1);

    // Randomized soak; the monitor does the checking.
    for (int i = 0; i < 20000; i++) begin
      fault     = ($urandom_range(0, 299) == 0);
      fault_clr = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 63) == 0) en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 99) == 0) duty_a = 8'($urandom);
      if ($urandom_range(0, 99) == 0) duty_b = 8'($urandom);
      if ($urandom_range(0, 99) == 0) duty_c = 8'($urandom);
      step();
    end
    fault = 1'b0; fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    chk("soak_clr_latch", 32'(fault_latched), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
